// File: rtl/median_pkg.sv
`default_nettype none
// ============================================================================
// Module      : median_pkg
// Description : Shared definitions for the median filter datapath: default
//               pixel width, 3x3 window element indices, packed window type.
// Revision    : 1.0 - initial release
// ============================================================================
package median_pkg;

  localparam int DATA_WIDTH = 8;

  // Window element k = 3*row + col; row 0 is the oldest row, col 0 the
  // oldest column.
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  typedef logic [9*DATA_WIDTH-1:0] window_t;

endpackage
`default_nettype wire

// File: rtl/window_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : window_pos_counter
// Description : Raster column/row position tracker for the 3x3 window builder.
//               Advances on each accepted pixel and wraps at the frame end.
// Ports       : clk        - clock
//               rst        - synchronous active-low reset
//               en         - pixel accepted this cycle
//               in_window  - current position completes a full 3x3 window
//               last_pixel - current position is the last pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module window_pos_counter #(
  parameter int WIDTH  = 5,
  parameter int HEIGHT = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic in_window,
  output logic last_pixel
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last;
  logic          row_last;

  assign col_last = (col == CW'(WIDTH - 1));
  assign row_last = (row == RW'(HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Flags describe the pixel being accepted now (pre-increment position).
  assign in_window  = (col >= CW'(2)) && (row >= RW'(2));
  assign last_pixel = col_last && row_last;

endmodule
`default_nettype wire

// File: rtl/median_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : median_window_3x3
// Description : Builds the 3x3 neighbourhood for the median filter from three
//               aligned row taps and flags windows lying fully inside the image.
// Ports       : clk          - clock
//               rst          - synchronous active-low reset
//               done_i       - pixel strobe, taps valid
//               data0_i      - current-row pixel (row r)
//               data1_i      - row r-1 pixel, same column
//               data2_i      - row r-2 pixel, same column
//               window_o     - packed window, element k at [DATA_WIDTH*k +: DATA_WIDTH]
//               done_o       - one-cycle window-valid pulse
//               frame_done_o - pulse with the last window of a frame
// Revision    : 1.0 - initial release
// ============================================================================
module median_window_3x3 #(
  parameter int WIDTH      = 5,
  parameter int HEIGHT     = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_i,
  input  logic [DATA_WIDTH-1:0]   data0_i,
  input  logic [DATA_WIDTH-1:0]   data1_i,
  input  logic [DATA_WIDTH-1:0]   data2_i,
  output logic [9*DATA_WIDTH-1:0] window_o,
  output logic                    done_o,
  output logic                    frame_done_o
);

  import median_pkg::*;

  logic [9*DATA_WIDTH-1:0] win_q;
  logic [9*DATA_WIDTH-1:0] win_next;
  logic                    in_window;
  logic                    last_pixel;

  window_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .en         (done_i),
    .in_window  (in_window),
    .last_pixel (last_pixel)
  );

  // Shift every row one column towards col 0 and load the taps into col 2.
  always_comb begin
    win_next = win_q;
    for (int r = 0; r < 3; r++) begin
      win_next[DATA_WIDTH*(3*r)   +: DATA_WIDTH] = win_q[DATA_WIDTH*(3*r+1) +: DATA_WIDTH];
      win_next[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] = win_q[DATA_WIDTH*(3*r+2) +: DATA_WIDTH];
    end
    win_next[DATA_WIDTH*WIN_TR +: DATA_WIDTH] = data2_i;
    win_next[DATA_WIDTH*WIN_MR +: DATA_WIDTH] = data1_i;
    win_next[DATA_WIDTH*WIN_BR +: DATA_WIDTH] = data0_i;
  end

  // Output window only refreshes on valid windows so it holds between
  // pulses; stale columns across a row wrap never reach the output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_q        <= '0;
      window_o     <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o       <= done_i && in_window;
      frame_done_o <= done_i && last_pixel;
      if (done_i) begin
        win_q <= win_next;
        if (in_window) begin
          window_o <= win_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_median_window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_median_window_3x3
// Description : Directed self-checking bench for median_window_3x3 with a
//               5x5 image streamed as pixel values 1..25 in raster order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_median_window_3x3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done_i = 1'b0;
  logic [7:0]  data0_i = '0;
  logic [7:0]  data1_i = '0;
  logic [7:0]  data2_i = '0;
  logic [71:0] window_o;
  logic        done_o;
  logic        frame_done_o;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int frames      = 0;

  median_window_3x3 #(
    .WIDTH      (5),
    .HEIGHT     (5),
    .DATA_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .done_i       (done_i),
    .data0_i      (data0_i),
    .data1_i      (data1_i),
    .data2_i      (data2_i),
    .window_o     (window_o),
    .done_o       (done_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] pack9(input int a, b, c, d, e, f, g, h, i);
    logic [71:0] w;
    w = {8'(i), 8'(h), 8'(g), 8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
    return w;
  endfunction

  // Window completed by the pixel at (r,c): element 3*i+j is pixel
  // (r-2+i, c-2+j), whose raster value is 5*row+col+1.
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = 8'(5*(r-2+i) + (c-2+j) + 1);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one pixel at (r,c), then check the registered outputs after the edge.
  task automatic pixel(input int r, input int c);
    logic valid;
    logic last;
    @(negedge clk);
    done_i  = 1'b1;
    data0_i = 8'(5*r + c + 1);
    data1_i = (r >= 1) ? 8'(5*(r-1) + c + 1) : 8'd0;
    data2_i = (r >= 2) ? 8'(5*(r-2) + c + 1) : 8'd0;
    @(posedge clk);
    #1;
    valid = (r >= 2) && (c >= 2);
    last  = (r == 4) && (c == 4);
    if (done_o === 1'b1) pulses++;
    if (frame_done_o === 1'b1) frames++;
    chk($sformatf("done_o@%0d,%0d", r, c), 72'(done_o), 72'(valid));
    chk($sformatf("frame_done_o@%0d,%0d", r, c), 72'(frame_done_o), 72'(last));
    if (valid) chk($sformatf("window@%0d,%0d", r, c), window_o, exp_win(r, c));
  endtask

  task automatic idle();
    @(negedge clk);
    done_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset window_o", window_o, 72'd0);
    chk("reset done_o", 72'(done_o), 72'd0);
    chk("reset frame_done_o", 72'(frame_done_o), 72'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- frame A: continuous, with gap after pixel 14 ----------
    pulses = 0; frames = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        pixel(r, c);
        if (r == 2 && c == 2)
          chk("first window", window_o, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
        if (r == 2 && c == 3) begin
          for (int g = 0; g < 3; g++) begin
            idle();
            chk("gap done_o", 72'(done_o), 72'd0);
            chk("gap window hold", window_o, pack9(2, 3, 4, 7, 8, 9, 12, 13, 14));
          end
        end
        if (r == 2 && c == 4)
          chk("after gap window", window_o, pack9(3, 4, 5, 8, 9, 10, 13, 14, 15));
        if (r == 3 && c == 2)
          chk("row wrap window", window_o, pack9(6, 7, 8, 11, 12, 13, 16, 17, 18));
        if (r == 4 && c == 4)
          chk("last window", window_o, pack9(13, 14, 15, 18, 19, 20, 23, 24, 25));
      end
    end
    idle();
    chk("idle done_o", 72'(done_o), 72'd0);
    chk("frame A pulses", 72'(pulses), 72'd9);
    chk("frame A frame_done", 72'(frames), 72'd1);

    // ---------------- reset mid-frame ----------------
    for (int p = 0; p < 19; p++) pixel(p / 5, p % 5);
    @(negedge clk);
    done_i = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset window_o", window_o, 72'd0);
    chk("midreset done_o", 72'(done_o), 72'd0);
    chk("midreset frame_done_o", 72'(frame_done_o), 72'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0; frames = 0;
    for (int p = 0; p < 25; p++) begin
      pixel(p / 5, p % 5);
      if (p == 12)
        chk("restream first window", window_o, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    end
    idle();
    chk("restream pulses", 72'(pulses), 72'd9);
    chk("restream frame_done", 72'(frames), 72'd1);

    // ---------------- back-to-back frames ----------------
    pulses = 0; frames = 0;
    for (int p = 0; p < 50; p++) begin
      pixel((p % 25) / 5, p % 5);
      if (p == 37)
        chk("frame2 first window", window_o, pack9(1, 2, 3, 6, 7, 8, 11, 12, 13));
    end
    idle();
    chk("b2b pulses", 72'(pulses), 72'd18);
    chk("b2b frame_done", 72'(frames), 72'd2);
    chk("b2b hold window", window_o, pack9(13, 14, 15, 18, 19, 20, 23, 24, 25));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/median_window_3x3.md
# median_window_3x3

Builds the 3x3 pixel neighbourhood for the median filter from three aligned row taps: the live pixel and the outputs of two cascaded line buffers. It sits directly downstream of the line buffer pair in the median preparation module and feeds the median sorting network. It tracks column and row position, and emits a window only when all nine pixels lie inside the image (no padding).

## Interface
- `WIDTH`, 5: image width in pixels; equals the line buffer `DEPTH`; must be ≥ 3.
- `HEIGHT`, 5: image height in rows; must be ≥ 3.
- `DATA_WIDTH`, 8: pixel width in bits.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous and active-low.
- `done_i`  in  1  pixel strobe; the three taps are valid this cycle.
- `data0_i`  in  DATA_WIDTH  current-row pixel (row r).
- `data1_i`  in  DATA_WIDTH  first line buffer output (row r-1, same column).
- `data2_i`  in  DATA_WIDTH  second line buffer output (row r-2, same column).
- `window_o`  out  9*DATA_WIDTH  packed window; element k = 3*row + col at `[DATA_WIDTH*k +: DATA_WIDTH]`; row 0 = oldest row (`data2_i`), col 0 = oldest column.
- `done_o`  out  1  window valid; one-cycle pulse per window.
- `frame_done_o`  out  1  one-cycle pulse coincident with the last window of a frame.

## Operation
- Column alignment of the three taps is done upstream. This block trusts them whenever `done_i` = 1.
- On `done_i` = 1:
  - Shift the 3x3 register left by one column: column 0 is dropped, and column 2 loads `{data2_i, data1_i, data0_i}` into rows 0/1/2.
  - Advance the column counter `col` (0..WIDTH-1). On wrap, `col` returns to 0 and the row counter `row` increments (0..HEIGHT-1).
  - On `col` = WIDTH-1 and `row` = HEIGHT-1, both counters return to 0 for the next frame.
- When `done_i` = 0, the shift register and counters hold, and `done_o` = 0.
- Window validity is evaluated on the pre-increment counters of the accepted pixel: `col` ≥ 2 and `row` ≥ 2.
  - This gives (WIDTH-2)*(HEIGHT-2) windows per frame.
- Windows straddling a row wrap are never flagged, because `col` < 2 at the start of each row. Stale columns from the previous row are therefore harmless.
- `frame_done_o` = 1 together with `done_o` for the pixel at `col` = WIDTH-1, `row` = HEIGHT-1.
- Counter widths are `$clog2(WIDTH)` and `$clog2(HEIGHT)`. Comparisons are unsigned, with no overflow past the wrap value.

## Timing
- Latency: `window_o` and `done_o` are registered. They appear one cycle after the `done_i` cycle that completes the window.
- `window_o` holds its last value between pulses. It changes only on accepted pixels.
- Back-to-back `done_i` gives back-to-back `done_o` within a row. Gaps in `done_i` create identical gaps in `done_o`.
- Reset (`rst` = 0 at a clock edge) forces the following, taking priority over `done_i`:
  - `window_o` = 0, `done_o` = 0, `frame_done_o` = 0;
  - `col` = 0, `row` = 0;
  - shift register cleared.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as (0,0).
- A new frame may start in the cycle immediately after the last pixel, with no idle cycle.

## Structure
- Shared package `median_pkg` holds:
  - `DATA_WIDTH`;
  - window index localparams (`WIN_TL` … `WIN_BR`, k = 0..8);
  - a packed window typedef `window_t` used by the sorter.
- One sub-module, `window_pos_counter`, holds `col`/`row` with enable and wrap. It outputs `in_window` and `last_pixel` flags. The 3x3 shift register stays in the top level.

## Test plan
Use WIDTH = HEIGHT = 5 and stream pixel values 1..25 raster order, with row r taps `data0` = 5r+c+1, `data1` = 5(r-1)+c+1, `data2` = 5(r-2)+c+1 (0 when the row is negative).
- Continuous stream, 25 accepted pixels → exactly 9 `done_o` pulses.
  - The first pulse comes one cycle after pixel 13, with window {1,2,3,6,7,8,11,12,13}.
  - The last pulse comes one cycle after pixel 25, with window {13,14,15,18,19,20,23,24,25}, and `frame_done_o` = 1 only then.
- Row wrap: no `done_o` after pixels 16 or 17 (`col` 0/1). The window after pixel 18 is {6,7,8,11,12,13,16,17,18}.
- `done_i` gaps: insert 3 idle cycles after pixel 14 → `done_o` stays 0 during the gap, `window_o` holds {2,3,4,7,8,9,12,13,14}, and the next window is {3,4,5,8,9,10,13,14,15}.
- Reset mid-frame: assert `rst` = 0 for one cycle after pixel 19, then restream 1..25 → all outputs read 0 after the reset edge, and the 9 windows match the first scenario exactly.
- Back-to-back frames: two 25-pixel frames with no gap → 18 `done_o` pulses and 2 `frame_done_o` pulses. The first window of frame 2 equals the frame-1 first window.
